// File: rtl/mpsoc_ahb3_spram_initiator_if.sv
// rtl/mpsoc_ahb3_spram_initiator_if.sv - AHB3-Lite master bus bundle
interface mpsoc_ahb3_spram_initiator_if #(
  parameter int PLEN = 8,
  parameter int XLEN = 32
);
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic [XLEN-1:0] HRDATA;
  logic            HREADY;
  logic            HRESP;

  modport master (
    output HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/mpsoc_ahb3_spram_initiator.sv
// rtl/mpsoc_ahb3_spram_initiator.sv - AHB3-Lite burst initiator driven by a simple command port
module mpsoc_ahb3_spram_initiator #(
  parameter int PLEN = 8,
  parameter int XLEN = 32
) (
  input  logic            HRESETn,
  input  logic            HCLK,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [PLEN-1:0] addr_i,
  input  logic [2:0]      size_i,
  input  logic [3:0]      len_i,
  output logic            ack_o,
  input  logic [XLEN-1:0] wdata_i,
  output logic            wdata_rdy_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            rvalid_o,
  output logic            done_o,
  output logic            err_o,
  output logic            busy_o,
  mpsoc_ahb3_spram_initiator_if.master ahb
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] beats_q;
  logic       dphase_q;
  logic       load, addr_adv, data_ok, abort, fin_ok, fin_err;

  function automatic logic [2:0] burst_of(input logic [3:0] len);
    case (len)
      4'd0:    return 3'b000;
      4'd3:    return 3'b011;
      4'd7:    return 3'b101;
      4'd15:   return 3'b111;
      default: return 3'b001;
    endcase
  endfunction

  assign ahb.HPROT     = 4'b0011;
  assign ahb.HMASTLOCK = 1'b0;
  assign wdata_rdy_o   = addr_adv & ahb.HWRITE;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (load) state_d = S_ADDR;
      S_ADDR: begin
        if (abort)                          state_d = S_ERR;
        else if (addr_adv && beats_q == '0) state_d = S_LAST;
      end
      S_LAST: begin
        if (abort)       state_d = S_ERR;
        else if (fin_ok) state_d = load ? S_ADDR : S_IDLE;
      end
      default: if (fin_err) state_d = S_IDLE;
    endcase
  end

  // abort fires in the first ERROR cycle; only a beat already in its data phase can see it
  always_comb begin
    load     = 1'b0;
    addr_adv = 1'b0;
    data_ok  = 1'b0;
    abort    = 1'b0;
    fin_ok   = 1'b0;
    fin_err  = 1'b0;
    case (state_q)
      S_IDLE: load = req_i;
      S_ADDR: begin
        addr_adv = ahb.HREADY;
        data_ok  = dphase_q & ahb.HREADY & ~ahb.HRESP;
        abort    = dphase_q & ahb.HRESP & ~ahb.HREADY;
      end
      S_LAST: begin
        data_ok = ahb.HREADY & ~ahb.HRESP;
        abort   = ahb.HRESP & ~ahb.HREADY;
        fin_ok  = data_ok;
        load    = data_ok & req_i;
      end
      default: fin_err = ahb.HREADY;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ahb.HTRANS <= HT_IDLE;
      ahb.HADDR  <= '0;
      ahb.HWDATA <= '0;
      ahb.HWRITE <= 1'b0;
      ahb.HSIZE  <= '0;
      ahb.HBURST <= '0;
      beats_q    <= '0;
      dphase_q   <= 1'b0;
      ack_o      <= 1'b0;
      rvalid_o   <= 1'b0;
      rdata_o    <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      ack_o    <= load;
      rvalid_o <= data_ok & ~ahb.HWRITE;
      done_o   <= fin_ok | fin_err;
      err_o    <= fin_err;
      busy_o   <= (state_d != S_IDLE) | fin_ok | fin_err;
      if (data_ok && !ahb.HWRITE) rdata_o <= ahb.HRDATA;
      if (addr_adv && ahb.HWRITE) ahb.HWDATA <= wdata_i;
      if (addr_adv)                      dphase_q <= 1'b1;
      else if (ahb.HREADY || abort)      dphase_q <= 1'b0;
      // HWRITE still describes the completing data phase when a back-to-back load overwrites it
      if (load) begin
        ahb.HTRANS <= HT_NONSEQ;
        ahb.HADDR  <= addr_i;
        ahb.HWRITE <= we_i;
        ahb.HSIZE  <= size_i;
        ahb.HBURST <= burst_of(len_i);
        beats_q    <= len_i;
      end else if (abort) begin
        ahb.HTRANS <= HT_IDLE;
      end else if (addr_adv) begin
        if (beats_q == '0) begin
          ahb.HTRANS <= HT_IDLE;
        end else begin
          ahb.HTRANS <= HT_SEQ;
          ahb.HADDR  <= ahb.HADDR + (PLEN'(1) << ahb.HSIZE);
          beats_q    <= beats_q - 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mpsoc_ahb3_spram_initiator.sv
// tb/tb_mpsoc_ahb3_spram_initiator.sv - randomized scoreboard bench with AHB slave model
module tb_mpsoc_ahb3_spram_initiator;
  localparam int PLEN = 8;
  localparam int XLEN = 32;

  logic            HCLK    = 1'b0;
  logic            HRESETn = 1'b0;
  logic            req_i   = 1'b0;
  logic            we_i    = 1'b0;
  logic [7:0]      addr_i  = '0;
  logic [2:0]      size_i  = '0;
  logic [3:0]      len_i   = '0;
  logic [31:0]     wdata_i = '0;
  logic            ack_o, wdata_rdy_o, rvalid_o, done_o, err_o, busy_o;
  logic [31:0]     rdata_o;

  mpsoc_ahb3_spram_initiator_if #(.PLEN(PLEN), .XLEN(XLEN)) ahb ();

  mpsoc_ahb3_spram_initiator #(.PLEN(PLEN), .XLEN(XLEN)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .size_i(size_i), .len_i(len_i), .ack_o(ack_o), .wdata_i(wdata_i),
    .wdata_rdy_o(wdata_rdy_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .ahb(ahb)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [7:0] addr;
    logic [1:0] trans;
    logic [2:0] burst;
    logic [2:0] size;
    logic       we;
    bit         err;
    int         waits;
  } beat_t;

  beat_t       exp_addr[$];
  logic [31:0] exp_rdata[$];
  logic [31:0] exp_hwdata[$];
  logic [31:0] wsrc[$];
  bit          exp_done[$];
  int n_cmp = 0, n_bad = 0, n_ack = 0, n_issue = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event with no matching expectation", name);
  endtask

  function automatic logic [31:0] rd_of(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5a, a + 8'h33};
  endfunction

  function automatic logic [2:0] burst_model(input int beats);
    if (beats == 1)  return 3'b000;
    if (beats == 4)  return 3'b011;
    if (beats == 8)  return 3'b101;
    if (beats == 16) return 3'b111;
    return 3'b001;
  endfunction

  // wmode: -1 random waits, -2 no waits, k>=0 one wait state on beat k
  task automatic issue(input bit we, input logic [7:0] addr, input logic [2:0] size,
                       input logic [3:0] len, input int errb, input int wmode,
                       input logic [31:0] wd0, output bit done_at_ack);
    int    nbeats, last;
    bit    got;
    beat_t b;
    nbeats = int'(len) + 1;
    last   = (errb >= 0) ? errb : nbeats - 1;
    for (int k = 0; k <= last; k++) begin
      b.addr  = 8'(int'(addr) + (k << size));
      b.trans = (k == 0) ? 2'b10 : 2'b11;
      b.burst = burst_model(nbeats);
      b.size  = size;
      b.we    = we;
      b.err   = (k == errb);
      b.waits = (wmode == -1) ? int'($urandom_range(0, 2)) : ((wmode == k) ? 1 : 0);
      exp_addr.push_back(b);
      if (we) begin
        logic [31:0] d;
        d = (wd0 != 0) ? wd0 + 32'(k) : $urandom;
        wsrc.push_back(d);
        if (k != errb) exp_hwdata.push_back(d);
      end else if (k != errb) begin
        exp_rdata.push_back(rd_of(b.addr));
      end
    end
    exp_done.push_back(errb >= 0);
    req_i = 1'b1; we_i = we; addr_i = addr; size_i = size; len_i = len;
    got = 1'b0;
    done_at_ack = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge HCLK); #2;
      if (ack_o) begin got = 1'b1; done_at_ack = done_o; break; end
    end
    chk("ack_seen", got, 1);
    req_i = 1'b0;
    n_issue++;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge HCLK); #2;
      if (exp_addr.size() == 0 && exp_done.size() == 0 && !busy_o) begin ok = 1'b1; break; end
    end
    if (!ok) bad("drain_timeout");
  endtask

  task automatic rst_checks(input string p);
    chk({p, "_htrans"}, ahb.HTRANS, 0);
    chk({p, "_haddr"}, ahb.HADDR, 0);
    chk({p, "_hwdata"}, ahb.HWDATA, 0);
    chk({p, "_hwrite"}, ahb.HWRITE, 0);
    chk({p, "_hsize"}, ahb.HSIZE, 0);
    chk({p, "_hburst"}, ahb.HBURST, 0);
    chk({p, "_hprot"}, ahb.HPROT, 4'b0011);
    chk({p, "_hmastlock"}, ahb.HMASTLOCK, 0);
    chk({p, "_ctrl"}, {ack_o, wdata_rdy_o, rvalid_o, done_o, err_o, busy_o}, 0);
    chk({p, "_rdata"}, rdata_o, 0);
  endtask

  // slave model and monitor: responses come from the expected-beat queue
  initial begin : slave_mon
    beat_t      dp_e, nb;
    bit         dp_valid, dp_errfirst, wpop, rdy, rsp, cerr, prev_stall;
    int         dp_wait;
    logic [1:0] prev_tr;
    logic [7:0] prev_ad;
    dp_valid = 0; dp_errfirst = 0; wpop = 0; prev_stall = 0; dp_wait = 0;
    prev_tr = '0; prev_ad = '0;
    ahb.HREADY = 1'b1; ahb.HRESP = 1'b0; ahb.HRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp_valid = 0; wpop = 0; prev_stall = 0;
        ahb.HREADY = 1'b1; ahb.HRESP = 1'b0;
      end else begin
        if (wpop) begin
          if (wsrc.size() > 0) void'(wsrc.pop_front());
          wpop = 0;
        end
        wdata_i = (wsrc.size() > 0) ? wsrc[0] : 32'h0;
        rdy = 1; rsp = 0; cerr = 0;
        ahb.HRDATA = $urandom;
        if (dp_valid) begin
          if (dp_wait > 0) begin
            rdy = 0; dp_wait--;
          end else if (dp_e.err) begin
            if (!dp_errfirst) begin rdy = 0; rsp = 1; dp_errfirst = 1; end
            else begin rsp = 1; cerr = 1; end
          end else if (!dp_e.we) begin
            ahb.HRDATA = rd_of(dp_e.addr);
          end
        end
        ahb.HREADY = rdy; ahb.HRESP = rsp;
        #1;
        if (prev_stall) begin
          chk("stall_htrans", ahb.HTRANS, prev_tr);
          chk("stall_haddr", ahb.HADDR, prev_ad);
        end
        if (cerr) chk("err2_htrans", ahb.HTRANS, 0);
        if (rvalid_o) begin
          if (exp_rdata.size() == 0) bad("rvalid_unexpected");
          else chk("rdata", rdata_o, exp_rdata.pop_front());
        end
        if (done_o) begin
          chk("done_busy", busy_o, 1);
          if (exp_done.size() == 0) bad("done_unexpected");
          else chk("done_err", err_o, exp_done.pop_front());
        end
        if (ack_o) n_ack++;
        if (wdata_rdy_o) begin
          if (wsrc.size() == 0) bad("wdata_rdy_unexpected");
          wpop = 1;
        end
        if (rdy && dp_valid && dp_e.we && !rsp) begin
          if (exp_hwdata.size() == 0) bad("hwdata_unexpected");
          else chk("hwdata", ahb.HWDATA, exp_hwdata.pop_front());
        end
        if (rdy && ahb.HTRANS[1]) begin
          if (exp_addr.size() == 0) begin
            bad("addr_unexpected");
            dp_valid = 0;
          end else begin
            nb = exp_addr.pop_front();
            chk("haddr", ahb.HADDR, nb.addr);
            chk("htrans", ahb.HTRANS, nb.trans);
            chk("hburst", ahb.HBURST, nb.burst);
            chk("hsize", ahb.HSIZE, nb.size);
            chk("hwrite", ahb.HWRITE, nb.we);
            chk("hprot_lock", {ahb.HPROT, ahb.HMASTLOCK}, 5'b00110);
            chk("wdata_rdy", wdata_rdy_o, nb.we);
            dp_e = nb; dp_valid = 1; dp_wait = nb.waits; dp_errfirst = 0;
          end
        end else begin
          chk("wdata_rdy_idle", wdata_rdy_o, 0);
          if (rdy) dp_valid = 0;
        end
        prev_stall = !rdy && !rsp && ahb.HTRANS[1];
        prev_tr = ahb.HTRANS;
        prev_ad = ahb.HADDR;
      end
    end
  end

  initial begin : driver
    bit          dd;
    bit          we;
    logic [2:0]  sz;
    logic [3:0]  ln;
    logic [7:0]  ad;
    int          eb;
    repeat (3) @(negedge HCLK);
    #2 rst_checks("reset");
    #1 HRESETn = 1'b1;

    issue(1'b1, 8'h10, 3'd2, 4'd0, -1, -2, 32'hDEADBEEF, dd);
    drain();
    issue(1'b0, 8'h20, 3'd2, 4'd3, -1, 1, 32'h0, dd);
    drain();
    issue(1'b1, 8'h40, 3'd2, 4'd2, -1, -1, 32'h0, dd);
    drain();
    issue(1'b0, 8'h80, 3'd2, 4'd7, 2, -1, 32'h0, dd);
    drain();

    issue(1'b1, 8'h30, 3'd2, 4'd1, -1, -2, 32'h0, dd);
    issue(1'b0, 8'h50, 3'd2, 4'd0, -1, -2, 32'h0, dd);
    chk("b2b_done_at_ack", dd, 1);
    chk("b2b_nonseq", {ahb.HTRANS, ahb.HADDR}, {2'b10, 8'h50});
    drain();

    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 2));
      case ($urandom_range(0, 5))
        0:       ln = 4'd0;
        1:       ln = 4'd3;
        2:       ln = 4'd7;
        3:       ln = 4'd15;
        default: ln = 4'($urandom_range(0, 15));
      endcase
      ad = 8'($urandom) & ~8'((1 << sz) - 1);
      eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(ln))) : -1;
      issue(we, ad, sz, ln, eb, -1, 32'h0, dd);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    chk("ack_count", n_ack, n_issue);
    chk("left_addr", exp_addr.size(), 0);
    chk("left_rdata", exp_rdata.size(), 0);
    chk("left_hwdata", exp_hwdata.size(), 0);
    chk("left_wsrc", wsrc.size(), 0);

    // reset while beat 2 of an INCR8 read is in its address phase
    issue(1'b0, 8'h00, 3'd2, 4'd7, -1, -2, 32'h0, dd);
    @(negedge HCLK);
    @(negedge HCLK);
    #3 chk("rst_pre_haddr", ahb.HADDR, 8'h08);
    HRESETn = 1'b0;
    #1 rst_checks("midrst");
    exp_addr.delete(); exp_rdata.delete(); exp_done.delete();
    exp_hwdata.delete(); wsrc.delete();
    repeat (2) @(negedge HCLK);
    #3 HRESETn = 1'b1;
    repeat (10) @(negedge HCLK);
    #2 chk("post_rst_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
